// File: rtl/fir2d_dma_sequencer.sv
// fir2d_dma_sequencer
// Frame-level sequencer for the 3x3 2D FIR core. It first streams the TAPS
// coefficient beats (core_tc_set high), then one TAPS-beat burst per
// 10-pixel group with GAP idle clocks between bursts. It keeps at most
// MAX_OUT groups in flight and writes each 240-bit core result to the
// destination frame buffer at the group index.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, abort      frame start pulse / stop issuing and return to idle
//   busy, done        frame in progress / one-cycle end-of-frame pulse
//   src_rd_en/addr    source beat read (data returns one clock later)
//   src_rdata         source beat data
//   core_data/valid_dmac/tc_set   beat stream into the FIR core
//   core_valid_core/out           FIR core result strobe and word
//   dst_wr_en/addr/wdata/ready    destination write with backpressure
module fir2d_dma_sequencer #(
  parameter int DW      = 240,
  parameter int NGRP    = 207360,
  parameter int TAPS    = 9,
  parameter int GAP     = 4,
  parameter int MAX_OUT = 2,
  parameter int SAW     = 21,
  parameter int DAW     = 18
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  output logic           busy,
  output logic           done,
  output logic           src_rd_en,
  output logic [SAW-1:0] src_addr,
  input  logic [DW-1:0]  src_rdata,
  output logic [DW-1:0]  core_data,
  output logic           core_valid_dmac,
  output logic           core_tc_set,
  input  logic           core_valid_core,
  input  logic [DW-1:0]  core_out,
  output logic           dst_wr_en,
  output logic [DAW-1:0] dst_addr,
  output logic [DW-1:0]  dst_wdata,
  input  logic           dst_ready
);

  localparam int BW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int GW = $clog2(GAP + 1);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  localparam logic [BW-1:0]  LAST_BEAT = BW'(TAPS - 1);
  localparam logic [GW-1:0]  LAST_GAP  = GW'(GAP - 1);
  localparam logic [DAW-1:0] LAST_GRP  = DAW'(NGRP - 1);
  localparam logic [OW-1:0]  OUT_LIMIT = OW'(MAX_OUT);
  localparam logic [PW-1:0]  LAST_SLOT = PW'(MAX_OUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TAP,
    ST_GAP,
    ST_BURST,
    ST_DRAIN,
    ST_FIN
  } state_t;

  state_t state, state_nxt;

  logic [BW-1:0]  beat;
  logic [DAW-1:0] grp;
  logic [GW-1:0]  gap_cnt;
  logic [SAW-1:0] addr_cnt;
  logic [OW-1:0]  outstanding;

  logic issue;        // a source read is issued this clock
  logic tap;          // the issued read is a coefficient beat
  logic burst_last;   // the issued read is the last beat of a group burst
  logic frame_start;

  logic rd_tc;        // tc flag aligned with src_rd_en
  logic beat_v;       // src_rdata is valid this clock
  logic beat_tc;

  // Result FIFO
  logic [DW-1:0] fifo_mem [MAX_OUT];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [OW-1:0] fifo_cnt;
  logic          fifo_full, fifo_empty, push, pop, drained;

  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_FIN);
  assign fifo_full  = (fifo_cnt == OUT_LIMIT);
  assign fifo_empty = (fifo_cnt == '0);
  // Results are only accepted inside a frame, so stragglers after an abort
  // never reach the destination.
  assign push       = core_valid_core && busy && !fifo_full;
  assign pop        = !fifo_empty && dst_ready;
  // Everything written back once the write accepted this clock retires;
  // lets done follow the last write by a single clock.
  assign drained    = (fifo_cnt == OW'(pop)) && (outstanding == OW'(pop));

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every sequential update uses <= so all registers sample the
    // pre-edge values; blocking here would create order-dependent logic.
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned, which would infer a latch.
    state_nxt   = state;
    issue       = 1'b0;
    tap         = 1'b0;
    burst_last  = 1'b0;
    frame_start = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          state_nxt   = ST_TAP;
          frame_start = 1'b1;
        end
      end
      ST_TAP: begin
        issue = 1'b1;
        tap   = 1'b1;
        // Taps run straight into group 0 with no gap.
        if (beat == LAST_BEAT) state_nxt = ST_BURST;
      end
      ST_BURST: begin
        issue = 1'b1;
        if (beat == LAST_BEAT) begin
          burst_last = 1'b1;
          state_nxt  = (grp == LAST_GRP) ? ST_DRAIN : ST_GAP;
        end
      end
      ST_GAP: begin
        // A burst only starts when its result has a guaranteed FIFO slot.
        if (gap_cnt == LAST_GAP && outstanding < OUT_LIMIT) state_nxt = ST_BURST;
      end
      ST_DRAIN: begin
        if (drained) state_nxt = ST_FIN;
      end
      ST_FIN: begin
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (abort) begin
      state_nxt  = ST_IDLE;
      issue      = 1'b0;
      tap        = 1'b0;
      burst_last = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Issue counters. Source addresses are one contiguous run: taps at
  // 0..TAPS-1, then group g beat k at TAPS + g*TAPS + k.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat     <= '0;
      grp      <= '0;
      gap_cnt  <= '0;
      addr_cnt <= '0;
    end else if (abort || frame_start) begin
      beat     <= '0;
      grp      <= '0;
      gap_cnt  <= '0;
      addr_cnt <= '0;
    end else begin
      if (issue) begin
        addr_cnt <= addr_cnt + 1'b1;
        beat     <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
      end
      if (burst_last) grp <= grp + 1'b1;
      // Saturates at LAST_GAP so a throttled GAP resumes as soon as a slot frees.
      if (state == ST_GAP) begin
        if (gap_cnt != LAST_GAP) gap_cnt <= gap_cnt + 1'b1;
      end else begin
        gap_cnt <= '0;
      end
    end
  end

  // Groups issued but not yet written back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     outstanding <= '0;
    else if (abort) outstanding <= '0;
    else            outstanding <= outstanding + OW'(burst_last) - OW'(pop);
  end

  // ---------------------------------------------------------------------
  // Read and core beat pipeline: src_rd_en(t) -> src_rdata(t+1) -> core(t+2).
  // Not flushed by abort, so beats already in flight still reach the core.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_rd_en       <= 1'b0;
      src_addr        <= '0;
      rd_tc           <= 1'b0;
      beat_v          <= 1'b0;
      beat_tc         <= 1'b0;
      core_valid_dmac <= 1'b0;
      core_tc_set     <= 1'b0;
      core_data       <= '0;
    end else begin
      src_rd_en <= issue;
      if (issue) src_addr <= addr_cnt;
      rd_tc           <= issue && tap;
      beat_v          <= src_rd_en;
      beat_tc         <= rd_tc;
      core_valid_dmac <= beat_v;
      core_tc_set     <= beat_v && beat_tc;
      core_data       <= beat_v ? src_rdata : '0;
    end
  end

  // ---------------------------------------------------------------------
  // Result FIFO and destination write
  // ---------------------------------------------------------------------
  // NOTE: the storage array has no reset; only the pointers and count do.
  // An entry is never read before being written, and dst_wdata is gated
  // to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= core_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      dst_addr <= '0;
    end else if (abort || frame_start) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      dst_addr <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + 1'b1;
        dst_addr <= dst_addr + 1'b1;
      end
      fifo_cnt <= fifo_cnt + OW'(push) - OW'(pop);
    end
  end

  assign dst_wr_en = !fifo_empty;
  assign dst_wdata = fifo_empty ? '0 : fifo_mem[rd_ptr];

  // A result arriving with no free slot is dropped; the MAX_OUT issue
  // throttle makes this unreachable with a well-behaved core.
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(core_valid_core && busy && fifo_full));

endmodule

// File: tb/tb_fir2d_dma_sequencer.sv
// tb_fir2d_dma_sequencer
// Directed bench for fir2d_dma_sequencer with a 4-group frame. A source
// memory model returns an address-derived word one clock after each read;
// a core model XORs the 9 data beats of each burst and returns the result
// two clocks after the last beat. Expected results come from the address
// pattern alone.
module tb_fir2d_dma_sequencer;

  localparam int DW      = 240;
  localparam int NGRP    = 4;
  localparam int TAPS    = 9;
  localparam int GAP     = 4;
  localparam int MAX_OUT = 2;
  localparam int SAW     = 21;
  localparam int DAW     = 18;
  localparam int NREADS  = TAPS + NGRP * TAPS;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic           abort;
  logic           busy;
  logic           done;
  logic           src_rd_en;
  logic [SAW-1:0] src_addr;
  logic [DW-1:0]  src_rdata;
  logic [DW-1:0]  core_data;
  logic           core_valid_dmac;
  logic           core_tc_set;
  logic           core_valid_core;
  logic [DW-1:0]  core_out;
  logic           dst_wr_en;
  logic [DAW-1:0] dst_addr;
  logic [DW-1:0]  dst_wdata;
  logic           dst_ready;

  fir2d_dma_sequencer #(
    .DW(DW), .NGRP(NGRP), .TAPS(TAPS), .GAP(GAP),
    .MAX_OUT(MAX_OUT), .SAW(SAW), .DAW(DAW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done),
    .src_rd_en(src_rd_en), .src_addr(src_addr), .src_rdata(src_rdata),
    .core_data(core_data), .core_valid_dmac(core_valid_dmac),
    .core_tc_set(core_tc_set), .core_valid_core(core_valid_core),
    .core_out(core_out),
    .dst_wr_en(dst_wr_en), .dst_addr(dst_addr), .dst_wdata(dst_wdata),
    .dst_ready(dst_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_word(input int a);
    logic [DW-1:0] w;
    w           = '0;
    w[31:0]     = 32'(a) * 32'h9E37_79B1;
    w[127:96]   = ~32'(a);
    w[239:232]  = 8'(a + 1);
    return w;
  endfunction

  function automatic logic [DW-1:0] exp_result(input int g);
    logic [DW-1:0] acc;
    acc = '0;
    for (int k = 0; k < TAPS; k++) acc = acc ^ mem_word(TAPS + g * TAPS + k);
    return acc;
  endfunction

  // Source memory: data one clock after the read strobe, junk otherwise.
  always @(posedge clk) begin
    if (src_rd_en) src_rdata <= mem_word(int'(src_addr));
    else           src_rdata <= '1;
  end

  // Core model: XOR of the 9 data beats, 2-clock latency after the last beat.
  int            m_cnt;
  logic [DW-1:0] m_acc;
  logic          m_v1;
  logic [DW-1:0] m_r1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0; m_acc <= '0; m_v1 <= 1'b0; m_r1 <= '0;
      core_valid_core <= 1'b0; core_out <= '0;
    end else begin
      m_v1 <= 1'b0;
      if (core_valid_dmac) begin
        if (core_tc_set) begin
          m_cnt <= 0; m_acc <= '0;
        end else if (m_cnt == TAPS - 1) begin
          m_v1 <= 1'b1; m_r1 <= m_acc ^ core_data;
          m_cnt <= 0; m_acc <= '0;
        end else begin
          m_cnt <= m_cnt + 1; m_acc <= m_acc ^ core_data;
        end
      end
      core_valid_core <= m_v1;
      core_out        <= m_r1;
    end
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard state, owned by the stimulus process.
  int   cyc = 0;
  int   rd_addr[$];
  int   rd_cyc[$];
  int   wr_idx = 0;
  int   last_wr_cyc = -100;
  int   done_cnt = 0;
  int   done_cyc = -1;
  bit   h1_en = 1'b0, h2_en = 1'b0;
  int   h1_addr = 0, h2_addr = 0;

  // Advance one clock. The write snapshot is taken after the inputs for this
  // edge are set; outputs are sampled on the falling edge.
  task automatic tick();
    logic          wr;
    int            wa;
    int            wc;
    logic [DW-1:0] wd;
    wr = dst_wr_en && dst_ready;
    wa = int'(dst_addr);
    wd = dst_wdata;
    wc = cyc;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      h1_en = 1'b0;
      h2_en = 1'b0;
      return;
    end
    if (wr) begin
      check("dst_addr", DW'(wa), DW'(wr_idx));
      check("dst_wdata", wd, exp_result(wr_idx));
      wr_idx++;
      last_wr_cyc = wc;
    end
    check("core_valid", DW'(core_valid_dmac), DW'(h2_en));
    if (h2_en) begin
      check("core_data", core_data, mem_word(h2_addr));
      check("core_tc", DW'(core_tc_set), DW'(h2_addr < TAPS));
    end else begin
      check("core_data_idle", core_data, '0);
      check("core_tc_idle", DW'(core_tc_set), '0);
    end
    h2_en   = h1_en;
    h2_addr = h1_addr;
    h1_en   = src_rd_en;
    h1_addr = int'(src_addr);
    if (src_rd_en) begin
      rd_addr.push_back(int'(src_addr));
      rd_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, DW'({src_rd_en, busy, done, core_valid_dmac, core_tc_set, dst_wr_en}), '0);
    check({tag, "_addr"}, DW'({src_addr, dst_addr}), '0);
    check({tag, "_core_data"}, core_data, '0);
    check({tag, "_dst_wdata"}, dst_wdata, '0);
  endtask

  task automatic begin_frame();
    rd_addr.delete();
    rd_cyc.delete();
    wr_idx      = 0;
    last_wr_cyc = -100;
    done_cnt    = 0;
    done_cyc    = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) tick();
    check("done_seen", DW'(done_cnt != 0), DW'(1));
    tick();
    tick();
  endtask

  task automatic verify_frame(input bit chk_gaps);
    int seq_err;
    int gap_err;
    int exp_d;
    check("rd_count", DW'(rd_addr.size()), DW'(NREADS));
    seq_err = 0;
    foreach (rd_addr[i]) if (rd_addr[i] != i) seq_err++;
    check("rd_seq_err", DW'(seq_err), '0);
    if (chk_gaps) begin
      gap_err = 0;
      for (int i = 1; i < rd_cyc.size(); i++) begin
        exp_d = (i >= 2 * TAPS && i % TAPS == 0) ? GAP + 1 : 1;
        if (rd_cyc[i] - rd_cyc[i-1] != exp_d) gap_err++;
      end
      check("rd_gap_err", DW'(gap_err), '0);
    end
    check("wr_count", DW'(wr_idx), DW'(NGRP));
    check("done_latency", DW'(done_cyc), DW'(last_wr_cyc + 1));
    check("done_pulses", DW'(done_cnt), DW'(1));
    check("busy_end", DW'(busy), '0);
  endtask

  initial begin
    int sim_wr;
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    dst_ready = 1'b1;
    repeat (3) tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    // Nominal frame: taps, 4 bursts with 4-clock gaps, 4 writes, done.
    begin_frame();
    wait_done(400);
    verify_frame(1'b1);

    // Backpressure: two groups outstanding hold the sequencer in GAP.
    dst_ready = 1'b0;
    begin_frame();
    repeat (49) tick();
    check("bp_reads_held", DW'(rd_addr.size()), DW'(3 * TAPS));
    check("bp_issue_idle", DW'(cyc - rd_cyc[rd_cyc.size()-1] > 5), DW'(1));
    check("bp_wr_pending", DW'({dst_wr_en, busy}), DW'(2'b11));
    check("bp_no_writes", DW'(wr_idx), '0);
    dst_ready = 1'b1;
    wait_done(400);
    verify_frame(1'b0);

    // Abort on the 5th beat of group 1, then a clean rerun.
    begin_frame();
    for (int i = 0; i < 200 && !(src_rd_en && src_addr == SAW'(2 * TAPS + 4)); i++) tick();
    check("ab_reached", DW'(src_rd_en), DW'(1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_rd_off", DW'(src_rd_en), '0);
    check("ab_busy_off", DW'(busy), '0);
    repeat (30) tick();
    check("ab_rd_total", DW'(rd_addr.size()), DW'(2 * TAPS + 5));
    check("ab_wr_total", DW'(wr_idx), DW'(1));
    check("ab_no_done", DW'(done_cnt), '0);
    begin_frame();
    wait_done(400);
    verify_frame(1'b1);

    // Asynchronous reset in the middle of burst 0, then a full frame.
    begin_frame();
    for (int i = 0; i < 200 && rd_addr.size() < TAPS + 5; i++) tick();
    check("arst_mid_burst", DW'(src_rd_en), DW'(1));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("arst");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_idle", DW'(busy), '0);
    begin_frame();
    wait_done(400);
    verify_frame(1'b1);

    // Write accepted on the clock burst 1 completes; start while busy.
    dst_ready = 1'b0;
    begin_frame();
    for (int i = 0; i < 200 && !(src_rd_en && src_addr == SAW'(3 * TAPS - 2)); i++) tick();
    dst_ready = 1'b1;
    tick();
    dst_ready = 1'b0;
    sim_wr = last_wr_cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100 && rd_addr.size() < 4 * TAPS; i++) tick();
    check("sim_burst2_issued", DW'(rd_addr.size()), DW'(4 * TAPS));
    check("sim_wr_cycle", DW'(sim_wr), DW'(rd_cyc[3 * TAPS - 1] - 1));
    dst_ready = 1'b1;
    wait_done(400);
    verify_frame(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
